// File: rtl/conv_filter_scheduler.sv
// Shares one pipelined convolution engine across NUM_FILTERS filters: drops column-edge
// windows, issues each interior window once per filter and tags returning results.
module conv_filter_scheduler #(
  parameter int COLUMN_SIZE = 28,
  parameter int FRAME_ROWS  = 26,
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_FILTERS = 4,
  parameter int LATENCY     = 4,
  localparam int KK = KERNEL_SIZE * KERNEL_SIZE,
  localparam int FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
  localparam int IW = $clog2(KK + 1)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       cfg_we,
  input  logic [FW-1:0]              cfg_filter,
  input  logic [IW-1:0]              cfg_idx,
  input  logic [DATA_WIDTH-1:0]      cfg_wdata,
  input  logic                       start,
  input  logic [DATA_WIDTH*KK-1:0]   win_data,
  input  logic                       win_valid,
  output logic                       win_ready,
  output logic [DATA_WIDTH*KK-1:0]   eng_data,
  output logic [DATA_WIDTH*KK-1:0]   eng_weights,
  output logic [DATA_WIDTH-1:0]      eng_bias,
  output logic                       eng_valid,
  input  logic [DATA_WIDTH-1:0]      eng_result,
  output logic [DATA_WIDTH-1:0]      res_data,
  output logic [FW-1:0]              res_filter,
  output logic                       res_valid,
  output logic                       busy,
  output logic                       frame_done
);
  // state | meaning
  // IDLE  | config writes land in the bank, waiting for start
  // RUN   | accepting windows, issuing interior ones once per filter
  // DRAIN | all windows taken, waiting for the final result to leave the engine
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int CW = (COLUMN_SIZE > 1) ? $clog2(COLUMN_SIZE) : 1;
  localparam int RW = (FRAME_ROWS > 1) ? $clog2(FRAME_ROWS) : 1;
  localparam int TW = $clog2(LATENCY + 1);

  state_t            state, state_next;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              issuing;
  logic [FW-1:0]     issue_cnt;
  logic [TW-1:0]     tail_cnt;
  logic              accept, interior, last_win, issue_last;

  logic [DATA_WIDTH-1:0] bank [NUM_FILTERS][KK+1];
  logic                  tag_v [LATENCY];
  logic [FW-1:0]         tag_f [LATENCY];

  assign issue_last = (issue_cnt == FW'(NUM_FILTERS - 1));
  assign win_ready  = (state == RUN) && (!issuing || issue_last);
  assign accept     = win_valid && win_ready;
  assign interior   = (col <= CW'(COLUMN_SIZE - KERNEL_SIZE));
  assign last_win   = (row == RW'(FRAME_ROWS - 1)) && (col == CW'(COLUMN_SIZE - 1));
  assign eng_valid  = issuing;
  assign busy       = (state != IDLE);

  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (accept && last_win) state_next = DRAIN;
      DRAIN: begin
        // tail_cnt reaches zero LATENCY+1 cycles after the final issue
        if (!issuing && tail_cnt == '0) begin
          frame_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      issuing   <= 1'b0;
      issue_cnt <= '0;
      tail_cnt  <= '0;
      eng_data  <= '0;
    end else begin
      state <= state_next;

      if (state == IDLE && start) begin
        col <= '0;
        row <= '0;
      end else if (accept) begin
        if (col == CW'(COLUMN_SIZE - 1)) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      if (accept && interior) begin
        issuing   <= 1'b1;
        issue_cnt <= '0;
        eng_data  <= win_data;
      end else if (issuing) begin
        if (issue_last) begin
          issuing   <= 1'b0;
          issue_cnt <= '0;
        end else begin
          issue_cnt <= issue_cnt + 1'b1;
        end
      end

      if (issuing) tail_cnt <= TW'(LATENCY);
      else if (tail_cnt != '0) tail_cnt <= tail_cnt - 1'b1;
    end
  end

  // Bank deliberately has no reset so weights survive an aborted frame
  always_ff @(posedge clock) begin
    if (state == IDLE && cfg_we && cfg_idx <= IW'(KK))
      bank[cfg_filter][cfg_idx] <= cfg_wdata;
  end

  always_comb begin
    eng_weights = '0;
    for (int i = 0; i < KK; i++)
      eng_weights[i*DATA_WIDTH +: DATA_WIDTH] = bank[issue_cnt][i];
  end
  assign eng_bias = bank[issue_cnt][KK];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        tag_v[i] <= 1'b0;
        tag_f[i] <= '0;
      end
    end else begin
      tag_v[0] <= issuing;
      tag_f[0] <= issue_cnt;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_f[i] <= tag_f[i-1];
      end
    end
  end

  assign res_valid  = tag_v[LATENCY-1];
  assign res_filter = tag_f[LATENCY-1];
  assign res_data   = eng_result;

endmodule

// File: tb/tb_conv_filter_scheduler.sv
// Bench for conv_filter_scheduler: queue-based model of issues and results, stub engine
// echoing the issued bias after LATENCY cycles, plus hand-computed frame-level literals.
module tb_conv_filter_scheduler;
  localparam int COLUMN_SIZE = 28;
  localparam int FRAME_ROWS  = 26;
  localparam int KERNEL_SIZE = 3;
  localparam int DATA_WIDTH  = 16;
  localparam int NUM_FILTERS = 4;
  localparam int LATENCY     = 4;
  localparam int KK = KERNEL_SIZE * KERNEL_SIZE;
  localparam int FW = 2;
  localparam int IW = 4;
  localparam int WW = DATA_WIDTH * KK;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic cfg_we = 1'b0;
  logic [FW-1:0] cfg_filter = '0;
  logic [IW-1:0] cfg_idx = '0;
  logic [DATA_WIDTH-1:0] cfg_wdata = '0;
  logic start = 1'b0;
  logic [WW-1:0] win_data = '0;
  logic win_valid = 1'b0;
  logic win_ready;
  logic [WW-1:0] eng_data, eng_weights;
  logic [DATA_WIDTH-1:0] eng_bias;
  logic eng_valid;
  logic [DATA_WIDTH-1:0] eng_result = '0;
  logic [DATA_WIDTH-1:0] res_data;
  logic [FW-1:0] res_filter;
  logic res_valid, busy, frame_done;

  conv_filter_scheduler #(
    .COLUMN_SIZE(COLUMN_SIZE), .FRAME_ROWS(FRAME_ROWS), .KERNEL_SIZE(KERNEL_SIZE),
    .DATA_WIDTH(DATA_WIDTH), .NUM_FILTERS(NUM_FILTERS), .LATENCY(LATENCY)
  ) dut (
    .clock(clock), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_filter(cfg_filter),
    .cfg_idx(cfg_idx), .cfg_wdata(cfg_wdata), .start(start), .win_data(win_data),
    .win_valid(win_valid), .win_ready(win_ready), .eng_data(eng_data),
    .eng_weights(eng_weights), .eng_bias(eng_bias), .eng_valid(eng_valid),
    .eng_result(eng_result), .res_data(res_data), .res_filter(res_filter),
    .res_valid(res_valid), .busy(busy), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic [DATA_WIDTH-1:0] wmodel [NUM_FILTERS][KK+1];

  function automatic logic [WW-1:0] pack_w(input int f);
    logic [WW-1:0] r;
    for (int i = 0; i < KK; i++) r[i*DATA_WIDTH +: DATA_WIDTH] = wmodel[f][i];
    return r;
  endfunction

  function automatic logic [WW-1:0] mk(input int n);
    logic [WW-1:0] r;
    for (int i = 0; i < KK; i++) r[i*DATA_WIDTH +: DATA_WIDTH] = 16'(n * 11 + i * 3 + 1);
    return r;
  endfunction

  typedef struct packed { int cyc; int f; logic [WW-1:0] data; } iss_t;
  typedef struct packed { int cyc; int f; } res_t;
  iss_t iq[$];
  res_t rq[$];

  int cyc = 0;
  int acc_cnt = 0, res_cnt = 0, done_cnt = 0;
  int start_cyc = 0, done_cyc = 0, last_issue_cyc = -100;
  bit frm_active = 0;
  bit f2_seen = 0;
  logic [WW-1:0] f2_w = '0;
  logic [DATA_WIDTH-1:0] f2_b = '0;
  logic [DATA_WIDTH-1:0] hist [LATENCY];

  // Model and compare process: every cycle out of reset the issue/result/done strobes are checked
  always @(negedge clock) begin
    bit exp_iss, exp_res, exp_done;
    iss_t it;
    res_t rt;
    cyc++;
    if (!reset_n) begin
      iq.delete();
      rq.delete();
      frm_active = 0;
      for (int i = 0; i < LATENCY; i++) hist[i] = '0;
      eng_result = '0;
    end else begin
      exp_iss = (iq.size() > 0) && (iq[0].cyc == cyc);
      chk(eng_valid == exp_iss, "eng_valid", eng_valid, exp_iss);
      if (exp_iss) begin
        it = iq.pop_front();
        if (eng_valid) begin
          chkw("eng_data", eng_data, it.data);
          chkw("eng_weights", eng_weights, pack_w(it.f));
          chk(eng_bias == wmodel[it.f][KK], "eng_bias", eng_bias, wmodel[it.f][KK]);
          if (it.f == 2 && !f2_seen) begin
            f2_seen = 1;
            f2_w = eng_weights;
            f2_b = eng_bias;
          end
        end
        rq.push_back('{cyc: cyc + LATENCY, f: it.f});
        last_issue_cyc = cyc;
      end

      exp_res = (rq.size() > 0) && (rq[0].cyc == cyc);
      chk(res_valid == exp_res, "res_valid", res_valid, exp_res);
      if (res_valid) res_cnt++;
      if (exp_res) begin
        rt = rq.pop_front();
        if (res_valid) begin
          chk(res_filter == FW'(rt.f), "res_filter", res_filter, rt.f);
          chk(res_data == wmodel[rt.f][KK], "res_data", res_data, wmodel[rt.f][KK]);
        end
      end

      exp_done = frm_active && (acc_cnt == COLUMN_SIZE * FRAME_ROWS) && (iq.size() == 0) &&
                 (cyc == last_issue_cyc + LATENCY + 1);
      chk(frame_done == exp_done, "frame_done", frame_done, exp_done);
      if (frame_done) begin
        chk(!res_valid, "done_vs_res", res_valid, 0);
        done_cnt++;
        done_cyc = cyc;
        frm_active = 0;
      end

      if (start && !busy) begin
        start_cyc = cyc;
        acc_cnt = 0;
        res_cnt = 0;
        frm_active = 1;
      end

      if (win_valid && win_ready) begin
        if ((acc_cnt % COLUMN_SIZE) <= COLUMN_SIZE - KERNEL_SIZE)
          for (int f = 0; f < NUM_FILTERS; f++)
            iq.push_back('{cyc: cyc + 1 + f, f: f, data: win_data});
        acc_cnt++;
      end

      // Stub engine: returns the bias it was issued with, LATENCY cycles later
      for (int i = LATENCY - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = eng_valid ? eng_bias : '0;
      eng_result = hist[LATENCY-1];
    end
  end

  int wid = 0;

  task automatic cfg_write(input int f, input int idx, input logic [DATA_WIDTH-1:0] v);
    cfg_we = 1'b1;
    cfg_filter = FW'(f);
    cfg_idx = IW'(idx);
    cfg_wdata = v;
    @(posedge clock);
    #1 cfg_we = 1'b0;
  endtask

  task automatic run_frame(input int n_win);
    int sent, guard;
    bit acc;
    sent = 0;
    guard = 0;
    start = 1'b1;
    win_valid = 1'b1;
    win_data = mk(wid);
    @(posedge clock);
    #1 start = 1'b0;
    while (sent < n_win && guard < 20000) begin
      @(negedge clock);
      acc = win_valid && win_ready;
      @(posedge clock);
      #1;
      guard++;
      if (acc) begin
        sent++;
        wid++;
        win_data = mk(wid);
      end
    end
    win_valid = 1'b0;
    chk(sent == n_win, "windows_sent", sent, n_win);
  endtask

  task automatic wait_done(input int d0);
    int g;
    g = 0;
    while (done_cnt == d0 && g < 300) begin
      @(posedge clock);
      g++;
    end
    chk(done_cnt == d0 + 1, "frame_done_count", done_cnt, d0 + 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WW-1:0] exp_w;
    int d;
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    chk(win_ready == 0, "rst_win_ready", win_ready, 0);
    chk(eng_valid == 0, "rst_eng_valid", eng_valid, 0);
    chk(res_valid == 0, "rst_res_valid", res_valid, 0);
    chk(busy == 0, "rst_busy", busy, 0);
    chk(frame_done == 0, "rst_frame_done", frame_done, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    for (int f = 0; f < NUM_FILTERS; f++) begin
      for (int i = 0; i < KK; i++) begin
        wmodel[f][i] = (f == 2) ? 16'(i + 1) : 16'(f * 256 + i * 3 + 5);
        cfg_write(f, i, wmodel[f][i]);
      end
      wmodel[f][KK] = 16'(16 << f);
      cfg_write(f, KK, wmodel[f][KK]);
    end
    cfg_write(0, KK + 2, 16'h0BAD);

    // Frame 1: full continuous frame with config writes attempted mid-run
    d = done_cnt;
    fork
      run_frame(COLUMN_SIZE * FRAME_ROWS);
      begin
        repeat (50) @(posedge clock);
        #2 cfg_we = 1'b1; cfg_filter = 2'd2; cfg_idx = IW'(KK); cfg_wdata = 16'hDEAD;
        @(posedge clock);
        #2 cfg_idx = '0; cfg_wdata = 16'hBEEF;
        @(posedge clock);
        #2 cfg_we = 1'b0;
      end
    join
    wait_done(d);
    chk(res_cnt == 2704, "frame1_results", res_cnt, 2704);
    chk(done_cyc - start_cyc == 2760, "frame1_length", done_cyc - start_cyc, 2760);
    chk(acc_cnt == 728, "frame1_accepts", acc_cnt, 728);
    for (int i = 0; i < KK; i++) exp_w[i*DATA_WIDTH +: DATA_WIDTH] = 16'(i + 1);
    chk(f2_seen, "f2_issue_seen", f2_seen, 1);
    chkw("f2_weights_literal", f2_w, exp_w);
    chk(f2_b == 16'h0040, "f2_bias_literal", f2_b, 16'h0040);
    #1;
    chk(busy == 0, "busy_after_done", busy, 0);

    // Frame 2: aborted by a one-cycle reset while issues are in flight
    d = done_cnt;
    run_frame(100);
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk(eng_valid == 0, "abort_eng_valid", eng_valid, 0);
    chk(res_valid == 0, "abort_res_valid", res_valid, 0);
    chk(busy == 0, "abort_busy", busy, 0);
    chk(win_ready == 0, "abort_win_ready", win_ready, 0);
    chk(frame_done == 0, "abort_frame_done", frame_done, 0);
    @(posedge clock);
    #3 reset_n = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    chk(done_cnt == d, "abort_no_done", done_cnt, d);
    chk(busy == 0, "abort_idle", busy, 0);

    // Frame 3: full frame on the retained weights
    d = done_cnt;
    run_frame(COLUMN_SIZE * FRAME_ROWS);
    wait_done(d);
    chk(res_cnt == 2704, "frame3_results", res_cnt, 2704);
    chk(done_cyc - start_cyc == 2760, "frame3_length", done_cyc - start_cyc, 2760);
    #1;
    chk(busy == 0, "busy_after_frame3", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
